// File: rtl/hardroc_readout_ctrl.sv
// HARDROC readout: START_READOUT/CLK_READ to the chip, DOUT deserialised MSB-first into 16-bit FIFO words.
// StartReadout->START_READOUT 1 cycle, 16th bit->FifoWrEn 1 cycle; FifoFull backpressure via 1-deep hold (overflow drops).
module hardroc_readout_ctrl #(
  parameter int          CLK_DIV     = 2,
  parameter int          START_WIDTH = 4,
  parameter logic [15:0] TX_TIMEOUT  = 16'd4000
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        StartReadout,
  output logic        EndReadout,
  output logic        START_READOUT,
  output logic        CLK_READ,
  input  logic        TRANSMITON_B,
  input  logic        DOUT,
  output logic [15:0] FifoData,
  output logic        FifoWrEn,
  input  logic        FifoFull,
  output logic [15:0] WordCount,
  output logic        TimeoutErr,
  output logic        OverflowErr
);

  typedef enum logic [2:0] {IDLE, START, WAIT_TX, SHIFT, FLUSH, DONE} state_t;

  state_t      state_q;
  logic        tx_meta_q, tx_sync_q, dout_meta_q, dout_sync_q;
  logic [15:0] div_q, start_cnt_q, to_cnt_q;
  logic [15:0] shift_q, hold_q, fifo_dat_q, word_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic        hold_vld_q;
  logic        end_q, start_ro_q, clk_read_q, wr_en_q, tout_q, ovf_q;

  logic        toggle, sample, word_done, flush_word, new_vld;
  logic [4:0]  pad;
  logic [15:0] new_dat;

  // TRANSMITON_B idles high, so its synchroniser resets to the inactive level.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_meta_q   <= 1'b1;
      tx_sync_q   <= 1'b1;
      dout_meta_q <= 1'b0;
      dout_sync_q <= 1'b0;
    end else begin
      tx_meta_q   <= TRANSMITON_B;
      tx_sync_q   <= tx_meta_q;
      dout_meta_q <= DOUT;
      dout_sync_q <= dout_meta_q;
    end
  end

  assign toggle     = (div_q == 16'(CLK_DIV - 1));
  assign sample     = (state_q == SHIFT) && toggle && !clk_read_q;
  assign word_done  = sample && (bit_cnt_q == 4'd15);
  assign flush_word = (state_q == FLUSH) && (bit_cnt_q != 4'd0);
  assign pad        = 5'd16 - {1'b0, bit_cnt_q};
  assign new_vld    = word_done || flush_word;
  assign new_dat    = word_done ? {shift_q[14:0], dout_sync_q} : (shift_q << pad);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      start_cnt_q <= '0;
      to_cnt_q    <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      bit_cnt_q   <= '0;
      fifo_dat_q  <= '0;
      word_cnt_q  <= '0;
      end_q       <= 1'b0;
      start_ro_q  <= 1'b0;
      clk_read_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      tout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      end_q   <= 1'b0;

      // The older held word always drains first; a new word then takes the register.
      if (!FifoFull && hold_vld_q) begin
        wr_en_q    <= 1'b1;
        fifo_dat_q <= hold_q;
        word_cnt_q <= word_cnt_q + 16'd1;
        if (new_vld) hold_q <= new_dat;
        else         hold_vld_q <= 1'b0;
      end else if (!FifoFull && new_vld) begin
        wr_en_q    <= 1'b1;
        fifo_dat_q <= new_dat;
        word_cnt_q <= word_cnt_q + 16'd1;
      end else if (FifoFull && new_vld) begin
        if (hold_vld_q) begin
          ovf_q <= 1'b1;
        end else begin
          hold_q     <= new_dat;
          hold_vld_q <= 1'b1;
        end
      end

      if (state_q == WAIT_TX || state_q == SHIFT) begin
        if (toggle) begin
          div_q      <= '0;
          clk_read_q <= ~clk_read_q;
        end else begin
          div_q <= div_q + 16'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (StartReadout) begin
            state_q     <= START;
            start_ro_q  <= 1'b1;
            start_cnt_q <= '0;
            to_cnt_q    <= '0;
            div_q       <= '0;
            clk_read_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            tout_q      <= 1'b0;
            ovf_q       <= 1'b0;
          end
        end
        START: begin
          if (start_cnt_q == 16'(START_WIDTH - 1)) begin
            start_ro_q <= 1'b0;
            state_q    <= WAIT_TX;
          end else begin
            start_cnt_q <= start_cnt_q + 16'd1;
          end
        end
        WAIT_TX: begin
          if (!tx_sync_q) begin
            state_q <= SHIFT;
          end else if (to_cnt_q == TX_TIMEOUT - 16'd1) begin
            tout_q     <= 1'b1;
            end_q      <= 1'b1;
            clk_read_q <= 1'b0;
            state_q    <= DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        SHIFT: begin
          if (sample) begin
            shift_q   <= {shift_q[14:0], dout_sync_q};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
          if (tx_sync_q) begin
            clk_read_q <= 1'b0;
            state_q    <= FLUSH;
          end
        end
        FLUSH: begin
          // Partial word goes out first, then wait until the hold register is empty.
          if (flush_word) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end else if (!hold_vld_q) begin
            end_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign EndReadout    = end_q;
  assign START_READOUT = start_ro_q;
  assign CLK_READ      = clk_read_q;
  assign FifoData      = fifo_dat_q;
  assign FifoWrEn      = wr_en_q;
  assign WordCount     = word_cnt_q;
  assign TimeoutErr    = tout_q;
  assign OverflowErr   = ovf_q;

endmodule
